// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the impulse convolver
package audio_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        MAC,
        DRAIN,
        OUTPUT
    } conv_state_t;

    localparam int Q_FRAC            = 15;
    localparam int DEFAULT_MAX_TAPS  = 4096;
    localparam int DEFAULT_ACC_WIDTH = 40;

endpackage

// File: rtl/impulse_convolver_if.sv
// rtl/impulse_convolver_if.sv - audio stream, control and IR memory signals of the convolver
interface impulse_convolver_if
    import audio_pkg::*;
#(
    parameter int ADDR_W = $clog2(DEFAULT_MAX_TAPS)
);
    logic              audio_trigger;
    logic [15:0]       audio_in;
    logic              impulse_recorded;
    logic [15:0]       tap_count;
    logic [ADDR_W-1:0] ir_addr;
    logic [15:0]       ir_data;
    logic [15:0]       audio_out;
    logic              audio_out_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output audio_trigger, audio_in, impulse_recorded, tap_count, ir_data,
        input  ir_addr, audio_out, audio_out_valid, busy, overrun
    );

    modport slave (
        input  audio_trigger, audio_in, impulse_recorded, tap_count, ir_data,
        output ir_addr, audio_out, audio_out_valid, busy, overrun
    );
endinterface

// File: rtl/sample_history_buffer.sv
// rtl/sample_history_buffer.sv - dual-port sample history RAM with a two-cycle registered read
module sample_history_buffer
    import audio_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_MAX_TAPS,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);
    logic [15:0] mem [DEPTH];
    logic [15:0] rd_q;

    // Write port: one sample (or one zero during clear) per cycle.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: array read register followed by an output register.
    always_ff @(posedge clk_in) begin
        rd_q  <= mem[raddr];
        rdata <= rd_q;
    end
endmodule

// File: rtl/impulse_convolver.sv
// rtl/impulse_convolver.sv - per-sample FIR convolution of the input against a recorded impulse response
module impulse_convolver
    import audio_pkg::*;
#(
    parameter int MAX_TAPS  = DEFAULT_MAX_TAPS,
    parameter int ADDR_W    = $clog2(MAX_TAPS),
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
    input  logic               clk_in,
    input  logic               rst_in,
    impulse_convolver_if.slave bus
);
    localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1 << (Q_FRAC - 1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = ACC_WIDTH'(-32768);

    conv_state_t                  state;
    logic [ADDR_W-1:0]            clr_cnt;
    logic [ADDR_W-1:0]            wp;
    logic [ADDR_W-1:0]            taps_m1;
    logic [ADDR_W-1:0]            ir_addr_q;
    logic [1:0]                   drain_cnt;
    logic                         issue_v, v1, v2, v3;
    logic signed [31:0]           prod;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  rounded, shifted;
    logic [15:0]                  sat_val;
    logic [15:0]                  audio_out_q;
    logic                         audio_out_valid_q;
    logic                         overrun_q;
    logic                         ir_rec_q;

    logic                         hist_we;
    logic [ADDR_W-1:0]            hist_waddr;
    logic [15:0]                  hist_wdata;
    logic [ADDR_W-1:0]            hist_raddr;
    logic [15:0]                  hist_rdata;

    sample_history_buffer #(
        .DEPTH  (MAX_TAPS),
        .ADDR_W (ADDR_W)
    ) u_history (
        .clk_in (clk_in),
        .we     (hist_we),
        .waddr  (hist_waddr),
        .wdata  (hist_wdata),
        .raddr  (hist_raddr),
        .rdata  (hist_rdata)
    );

    // Newest sample sits at wp, so tap k reads k samples back with natural wrap.
    assign hist_raddr          = wp - ir_addr_q;
    assign bus.ir_addr         = ir_addr_q;
    assign bus.audio_out       = audio_out_q;
    assign bus.audio_out_valid = audio_out_valid_q;
    assign bus.overrun         = overrun_q;
    assign bus.busy            = (state == CLEAR) || (state == MAC) || (state == DRAIN);

    // History write port: zero-fill while clearing, otherwise store each accepted sample.
    always_comb begin
        hist_we    = 1'b0;
        hist_waddr = wp;
        hist_wdata = bus.audio_in;
        if (state == CLEAR) begin
            hist_we    = 1'b1;
            hist_waddr = clr_cnt;
            hist_wdata = '0;
        end else if (state == IDLE && bus.audio_trigger) begin
            hist_we    = 1'b1;
        end
    end

    // Round to nearest in Q1.15 and clamp to the 16-bit signed range.
    always_comb begin
        rounded = acc + ROUND_HALF;
        shifted = rounded >>> Q_FRAC;
        if (shifted > SAT_MAX) begin
            sat_val = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = shifted[15:0];
        end
    end

    // Control FSM plus the read/multiply/accumulate pipeline.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= CLEAR;
            clr_cnt           <= '0;
            wp                <= '0;
            taps_m1           <= '0;
            ir_addr_q         <= '0;
            drain_cnt         <= '0;
            issue_v           <= 1'b0;
            v1                <= 1'b0;
            v2                <= 1'b0;
            v3                <= 1'b0;
            prod              <= '0;
            acc               <= '0;
            audio_out_q       <= '0;
            audio_out_valid_q <= 1'b0;
            overrun_q         <= 1'b0;
            ir_rec_q          <= 1'b0;
        end else begin
            audio_out_valid_q <= 1'b0;
            ir_rec_q          <= bus.impulse_recorded;
            v1                <= issue_v;
            v2                <= v1;
            v3                <= v2;
            if (v2) begin
                prod <= $signed(hist_rdata) * $signed(bus.ir_data);
            end
            if (v3) begin
                acc <= acc + {{(ACC_WIDTH-32){prod[31]}}, prod};
            end
            // A fresh recording starts a new session, so the sticky overrun is dropped.
            if (bus.impulse_recorded && !ir_rec_q) begin
                overrun_q <= 1'b0;
            end

            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(MAX_TAPS - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.audio_trigger) begin
                        if (!bus.impulse_recorded || bus.tap_count == 16'd0) begin
                            audio_out_q       <= bus.audio_in;
                            audio_out_valid_q <= 1'b1;
                            wp                <= wp + ADDR_W'(1);
                        end else begin
                            taps_m1   <= (bus.tap_count > 16'(MAX_TAPS)) ? ADDR_W'(MAX_TAPS - 1)
                                                                          : ADDR_W'(bus.tap_count - 16'd1);
                            acc       <= '0;
                            ir_addr_q <= '0;
                            issue_v   <= 1'b1;
                            state     <= MAC;
                        end
                    end
                end
                MAC: begin
                    if (bus.audio_trigger) begin
                        overrun_q <= 1'b1;
                    end
                    if (ir_addr_q == taps_m1) begin
                        issue_v   <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        ir_addr_q <= ir_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (bus.audio_trigger) begin
                        overrun_q <= 1'b1;
                    end
                    if (drain_cnt == 2'd2) begin
                        state <= OUTPUT;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                OUTPUT: begin
                    // The result register is being loaded this cycle, so a trigger here is lost too.
                    if (bus.audio_trigger) begin
                        overrun_q <= 1'b1;
                    end
                    audio_out_q       <= sat_val;
                    audio_out_valid_q <= 1'b1;
                    wp                <= wp + ADDR_W'(1);
                    state             <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
